fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the multicycle MIPS core, directly upstream of the controller.
//  Holds the PC and issues word reads to instruction memory over a req/ack handshake.
//  Latches the returned word into an instruction register and presents op/funct to the controller.
//  Consumes the controller's pcsrc/jump to select the next PC; counts retired instructions.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset (must be word aligned)
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  imem_req     out  1      read request to instruction memory
//  imem_addr    out  32     byte address of request, [1:0] always 2'b00
//  imem_ack     in   1      memory accepted request; imem_rdata valid this cycle
//  imem_rdata   in   32     instruction word
//  stall        in   1      downstream cannot retire the held instruction
//  pcsrc        in   1      from controller: take branch
//  jump         in   1      from controller: take jump
//  signimm      in   32     sign-extended immediate of held instruction
//  instr        out  32     instruction register
//  instr_valid  out  1      instr holds a fetched, not-yet-retired instruction
//  op           out  6      instr[31:26]
//  funct        out  6      instr[5:0]
//  pc           out  32     address of held instruction
//  pcplus4      out  32     pc + 4
//  retired      out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: IDLE -> FETCH -> VALID -> FETCH ...; 2-bit encoding.
//  Reset (any state): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0.
//  IDLE: imem_req=0; unconditionally -> FETCH next cycle.
//  FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack.
//   imem_ack=1 at edge: instr<=imem_rdata, -> VALID. ack may come the first FETCH cycle.
//  VALID: instr_valid=1, imem_req=0. pcsrc/jump/signimm sampled only here.
//   stall=1: hold everything. stall=0 at edge: retire -> pc<=next_pc,
//   retired<=retired+1, -> FETCH.
//  next_pc: jump ? {pcplus4[31:28], instr[25:0], 2'b00}
//         : pcsrc ? pcplus4 + (signimm << 2) : pcplus4. jump has priority.
//  Arithmetic 32-bit modulo; pc 32'hFFFF_FFFC + 4 wraps to 0, no flag.
//  Latency: ack in cycle N -> instr_valid in N+1; minimum 2 cycles/instruction.
//  imem_ack outside FETCH is ignored (no state change, instr unchanged).
//  Reset during FETCH abandons the request: imem_req low the cycle after reset is sampled.
//  op/funct/pcplus4 combinational from instr/pc; op/funct are 0 while instr_valid=0.
// STRUCTURE
//  Shared header mips_defs.vh: opcode constants (J=6'h02, BEQ=6'h04), RESET_PC default,
//  fetch state encodings (S_IDLE, S_FETCH, S_VALID).
//  One sub-module: pc_next (combinational next_pc mux: pcplus4, signimm, instr[25:0],
//  pcsrc, jump -> next_pc). FSM, PC, IR, counter stay in fetch_unit.
// TESTING
//  1 reset, then ack on first FETCH cycle with 32'h2008_0005 -> imem_addr=0, instr_valid next
//    cycle, op=6'h08, pc=0; stall=0 -> next req at imem_addr=4, retired=1.
//  2 ack delayed 3 cycles -> imem_req and imem_addr=4 stable all 4 cycles; instr latched
//    only on ack cycle.
//  3 pc=0x10, pcsrc=1, signimm=32'hFFFF_FFFE, stall=0 -> next imem_addr=0x0C.
//  4 pc=0x4000_0000, jump=1 and pcsrc=1, instr[25:0]=26'h10 -> next imem_addr=0x4000_0040.
//  5 stall=1 for 5 cycles in VALID -> instr/pc/retired unchanged, imem_req=0; release -> advance.
//  6 reset asserted mid-FETCH with late ack -> imem_req=0, pc=RESET_PC,
//    instr_valid=0, retired=0; stray ack in IDLE ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, reset PC and FSM encoding.
package fetch_unit_pkg;

    localparam logic [5:0]  OpJ            = 6'h02;
    localparam logic [5:0]  OpBeq          = 6'h04;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StValid = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select: jump target, taken-branch target or fall-through. Jump wins over branch.
module fetch_unit_pc_next (
    input  logic [31:0] pcplus4_i,
    input  logic [31:0] signimm_i,
    input  logic [25:0] instr_idx_i,
    input  logic        pcsrc_i,
    input  logic        jump_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign branch_target = pcplus4_i + {signimm_i[29:0], 2'b00};
    assign jump_target   = {pcplus4_i[31:28], instr_idx_i, 2'b00};

    always_comb begin
        next_pc_o = pcplus4_i;
        if (jump_i) begin
            next_pc_o = jump_target;
        end else if (pcsrc_i) begin
            next_pc_o = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle MIPS fetch stage: PC, instruction register, imem req/ack handshake and
// retired-instruction counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic [31:0]      signimm,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [31:0]      pc,
    output logic [31:0]      pcplus4,
    output logic [CNT_W-1:0] retired
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [31:0]      next_pc;

    assign pcplus4 = pc_q + 32'd4;

    fetch_unit_pc_next u_pc_next (
        .pcplus4_i   (pcplus4),
        .signimm_i   (signimm),
        .instr_idx_i (instr_q[25:0]),
        .pcsrc_i     (pcsrc),
        .jump_i      (jump),
        .next_pc_o   (next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StValid;
                end
            end
            StValid: begin
                // Controller inputs are only meaningful while the instruction is held.
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign instr       = instr_q;
    assign instr_valid = (state_q == StValid);
    assign op          = instr_valid ? instr_q[31:26] : 6'h0;
    assign funct       = instr_valid ? instr_q[5:0] : 6'h0;
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle comparison against a behavioural model plus
// hand-computed checks for each scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] retired;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .signimm     (signimm),
        .instr       (instr),
        .instr_valid (instr_valid),
        .op          (op),
        .funct       (funct),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a request is outstanding until acked, the word is then held until
    // released by a cycle without stall, after which the next request goes out immediately.
    logic [31:0] m_pc, m_instr, m_ret;
    bit          m_fetching, m_holding;

    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                               input bit j, input bit br, input logic [31:0] imm);
        logic [31:0] seq;
        seq = cur_pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (br) return seq + imm * 32'd4;
        return seq;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0;
            m_fetching = 1'b0; m_holding = 1'b0;
        end else if (m_holding) begin
            if (!stall) begin
                m_pc = model_next(m_pc, m_instr, jump, pcsrc, signimm);
                m_ret = m_ret + 32'd1;
                m_holding = 1'b0; m_fetching = 1'b1;
            end
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_holding = 1'b1; m_fetching = 1'b0;
            end
        end else begin
            m_fetching = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_req",     {31'b0, imem_req},    {31'b0, m_fetching});
            check("m_addr",    imem_addr,            m_pc);
            check("m_instr",   instr,                m_instr);
            check("m_valid",   {31'b0, instr_valid}, {31'b0, m_holding});
            check("m_op",      {26'b0, op},          m_holding ? {26'b0, m_instr[31:26]} : 32'h0);
            check("m_funct",   {26'b0, funct},       m_holding ? {26'b0, m_instr[5:0]} : 32'h0);
            check("m_pc",      pc,                   m_pc);
            check("m_pcplus4", pcplus4,              m_pc + 32'd4);
            check("m_retired", retired,              m_ret);
        end
    end

    // Waits (bounded) for a request, acks it after `delay` idle request cycles.
    task automatic do_fetch(input logic [31:0] word, input int delay);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            $display("FAIL req_timeout: got imem_req=0 expected 1 within 20 cycles");
            mismatched++;
        end
        repeat (delay) @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = 32'h0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_instr", instr, 32'h0);

        // 1: ack on first FETCH cycle
        reset = 1'b0;
        @(negedge clk);
        check("t1_req", {31'b0, imem_req}, 32'h1);
        check("t1_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        check("t1_valid", {31'b0, instr_valid}, 32'h1);
        check("t1_op", {26'b0, op}, 32'h08);
        check("t1_funct", {26'b0, funct}, 32'h05);
        check("t1_pc", pc, 32'h0);
        @(negedge clk);
        check("t1_next_addr", imem_addr, 32'h4);
        check("t1_retired", retired, 32'h1);

        // 2: ack delayed 3 cycles
        for (int i = 0; i < 3; i++) begin
            check("t2_req_hold", {31'b0, imem_req}, 32'h1);
            check("t2_addr_hold", imem_addr, 32'h4);
            check("t2_instr_hold", instr, 32'h2008_0005);
            @(negedge clk);
        end
        check("t2_req_ack", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        check("t2_instr", instr, 32'h0000_0020);
        check("t2_funct", {26'b0, funct}, 32'h20);
        @(negedge clk);
        do_fetch(32'h0000_0020, 1);
        @(negedge clk);
        do_fetch(32'h0000_0020, 0);
        @(negedge clk);

        // 3: backward branch from 0x10
        check("t3_addr_start", imem_addr, 32'h10);
        pcsrc = 1'b1; signimm = 32'hFFFF_FFFE;
        do_fetch(32'h1000_FFFE, 0);
        check("t3_op", {26'b0, op}, 32'h04);
        @(negedge clk);
        check("t3_addr", imem_addr, 32'h0C);
        check("t3_retired", retired, 32'h5);

        // 4: reach 0x4000_0000 by branch, then jump beats branch
        signimm = 32'h0FFF_FFFC;
        do_fetch(32'h1000_0000, 2);
        @(negedge clk);
        check("t4_addr_start", imem_addr, 32'h4000_0000);
        jump = 1'b1; pcsrc = 1'b1; signimm = 32'h5;
        do_fetch(32'h0800_0010, 0);
        check("t4_op", {26'b0, op}, 32'h02);
        @(negedge clk);
        check("t4_addr", imem_addr, 32'h4000_0040);
        jump = 1'b0; pcsrc = 1'b0; signimm = 32'h0;

        // 5: stall holds everything
        stall = 1'b1;
        do_fetch(32'h0000_0021, 0);
        for (int i = 0; i < 5; i++) begin
            check("t5_valid", {31'b0, instr_valid}, 32'h1);
            check("t5_req", {31'b0, imem_req}, 32'h0);
            check("t5_pc", pc, 32'h4000_0040);
            check("t5_retired", retired, 32'h7);
            @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        check("t5_addr", imem_addr, 32'h4000_0044);
        check("t5_retired_after", retired, 32'h8);

        // 6: reset mid-FETCH, then a stray ack while idle
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_req", {31'b0, imem_req}, 32'h0);
        check("t6_pc", pc, 32'h0);
        check("t6_valid", {31'b0, instr_valid}, 32'h0);
        check("t6_retired", retired, 32'h0);
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        check("t6_stray_instr", instr, 32'h0);
        check("t6_stray_valid", {31'b0, instr_valid}, 32'h0);
        check("t6_req_after", {31'b0, imem_req}, 32'h1);

        // 7: branch to the top word, then sequential wrap to zero
        pcsrc = 1'b1; signimm = 32'hFFFF_FFFE;
        do_fetch(32'h1000_FFFE, 0);
        @(negedge clk);
        check("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
        check("t7_pcplus4", pcplus4, 32'h0);
        pcsrc = 1'b0; signimm = 32'h0;
        do_fetch(32'h0000_0020, 1);
        @(negedge clk);
        check("t7_wrap", imem_addr, 32'h0);
        check("t7_retired", retired, 32'h2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
